// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU placed after the register bank.
// Single-cycle ops (ADD, SUB, AND, OR, PASS) finish through CONCLUI directly.
// MUL (16 shift-add steps) and shifts (one bit per cycle) iterate in EXECUTA.
// done/Hab_Escrita pulse for one cycle together with the new resultado/flags.
module ula_multiciclo #(
  parameter int bits_palavra = 16,
  parameter int bits_shamt   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              op,
  input  logic [bits_palavra-1:0] A,
  input  logic [bits_palavra-1:0] B,
  output logic                    busy,
  output logic                    done,
  output logic                    Hab_Escrita,
  output logic [bits_palavra-1:0] resultado,
  output logic                    flag_zero,
  output logic                    flag_carry
);

  localparam int W     = bits_palavra;
  localparam int CNT_W = $clog2(bits_palavra + 1);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    EXECUTA = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  estado_t            estado, proximo;
  logic [2:0]         op_reg;
  logic [W-1:0]       a_reg, b_reg;
  // MUL: high half is the partial sum, low half starts as the multiplier and
  // is shifted out as the product fills in. Shifts use only the low half.
  logic [2*W-1:0]     acc;
  logic               carry_desl;
  logic [CNT_W-1:0]   contador;
  logic [bits_shamt-1:0] shamt;
  logic [W:0]         final_calc;

  assign shamt       = B[bits_shamt-1:0];
  assign Hab_Escrita = done;

  // True when the operation must iterate in EXECUTA.
  function automatic logic precisa_iterar(input logic [2:0] o,
                                          input logic [bits_shamt-1:0] n);
    precisa_iterar = (o == OP_MUL) ||
                     (((o == OP_SHL) || (o == OP_SHR)) && (n != '0));
  endfunction

  // One shift-add multiply step: add multiplicand when multiplier LSB is set,
  // then shift the whole accumulator right by one (carry enters at the top).
  function automatic logic [2*W-1:0] passo_mul(input logic [2*W-1:0] ac,
                                               input logic [W-1:0] mcand);
    logic [W:0] soma;
    soma = {1'b0, ac[2*W-1:W]} + (ac[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    passo_mul = {soma, ac[W-1:1]};
  endfunction

  // Final {carry, result} from the latched operands and the iteration state.
  function automatic logic [W:0] calc_final(input logic [2:0] o,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [2*W-1:0] ac,
                                            input logic cd);
    case (o)
      OP_ADD:  calc_final = {1'b0, a} + {1'b0, b};
      OP_SUB:  calc_final = {(a < b), a - b};
      OP_AND:  calc_final = {1'b0, a & b};
      OP_OR:   calc_final = {1'b0, a | b};
      OP_MUL:  calc_final = {(ac[2*W-1:W] != '0), ac[W-1:0]};
      OP_SHL,
      OP_SHR:  calc_final = {cd, ac[W-1:0]};
      default: calc_final = {1'b0, a};
    endcase
  endfunction

  assign final_calc = calc_final(op_reg, a_reg, b_reg, acc, carry_desl);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) estado <= OCIOSO;
    else       estado <= proximo;
  end

  // Next-state logic and busy indication.
  always_comb begin
    proximo = estado;
    busy    = 1'b0;
    case (estado)
      OCIOSO: begin
        if (start) proximo = precisa_iterar(op, shamt) ? EXECUTA : CONCLUI;
      end
      EXECUTA: begin
        busy = 1'b1;
        if (contador == CNT_W'(1)) proximo = CONCLUI;
      end
      CONCLUI: proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
  end

  // Operand latch, iteration datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      carry_desl <= 1'b0;
      contador   <= '0;
      done       <= 1'b0;
      resultado  <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
    end else begin
      done <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (start) begin
            op_reg     <= op;
            a_reg      <= A;
            b_reg      <= B;
            carry_desl <= 1'b0;
            case (op)
              OP_MUL: begin
                acc      <= {{W{1'b0}}, B};
                contador <= CNT_W'(W);
              end
              OP_SHL, OP_SHR: begin
                acc      <= {{W{1'b0}}, A};
                contador <= CNT_W'(shamt);
              end
              default: begin
                acc      <= '0;
                contador <= '0;
              end
            endcase
          end
        end
        EXECUTA: begin
          contador <= contador - CNT_W'(1);
          case (op_reg)
            OP_MUL: acc <= passo_mul(acc, a_reg);
            OP_SHL: begin
              carry_desl   <= acc[W-1];
              acc[W-1:0]   <= {acc[W-2:0], 1'b0};
            end
            OP_SHR: begin
              carry_desl   <= acc[0];
              acc[W-1:0]   <= {1'b0, acc[W-1:1]};
            end
            default: acc <= acc;
          endcase
        end
        CONCLUI: begin
          resultado  <= final_calc[W-1:0];
          flag_carry <= final_calc[W];
          flag_zero  <= (final_calc[W-1:0] == '0);
          done       <= 1'b1;
        end
        default: done <= 1'b0;
      endcase
    end
  end

endmodule
